// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: MMIO LED sequencer with static, blink and rotate modes driven by a prescaler
// Registers (io_addr): 0=PATTERN, 1=MODE {EN@4, SEL@1:0}, 2=PERIOD, 3=STATUS {EN, steps[15:0]} (read-only)
// Ports: clk, rst (async, active-low), io_wr/io_rd/io_addr/write_data from the decoder,
//        read_data (registered), led_data (registered LED drive), step_tick (pulse per step)
module led_pattern_ctrl #(
  parameter int LED_W = 16,
  parameter int CNT_W = 24,
  parameter logic [CNT_W-1:0] RST_PERIOD = 24'd49999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             io_wr,
  input  logic             io_rd,
  input  logic [1:0]       io_addr,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  output logic [LED_W-1:0] led_data,
  output logic             step_tick
);
  logic [LED_W-1:0] pattern_q, pattern_d, work_q, work_d, led_q, led_d;
  logic [CNT_W-1:0] period_q, period_d, presc_q, presc_d;
  logic [15:0]      steps_q, steps_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       sel_q, sel_d;
  logic             en_q, en_d, phase_q, phase_d;
  logic             wr_hit, tick;
  always_comb begin
    // STATUS writes are dropped entirely, so they neither restart nor suppress a step
    wr_hit    = io_wr && io_addr != 2'd3;
    tick      = en_q && presc_q == period_q && !wr_hit;
    pattern_d = (io_wr && io_addr == 2'd0) ? write_data[LED_W-1:0] : pattern_q;
    en_d      = (io_wr && io_addr == 2'd1) ? write_data[4] : en_q;
    sel_d     = (io_wr && io_addr == 2'd1) ? write_data[1:0] : sel_q;
    period_d  = (io_wr && io_addr == 2'd2) ? write_data[CNT_W-1:0] : period_q;
    presc_d   = (wr_hit || tick || !en_q) ? '0 : presc_q + CNT_W'(1);
    phase_d   = wr_hit ? 1'b0 : (tick && sel_q == 2'd1) ? !phase_q : phase_q;
    // pattern_d already carries a fresh PATTERN write, so every restart reloads the right value
    work_d    = wr_hit ? pattern_d :
                !tick ? work_q :
                sel_q == 2'd2 ? {work_q[LED_W-2:0], work_q[LED_W-1]} :
                sel_q == 2'd3 ? {work_q[0], work_q[LED_W-1:1]} : work_q;
    steps_d   = tick ? steps_q + 16'd1 : steps_q;
    led_d     = !en_q ? pattern_q : (sel_q == 2'd1 && phase_q) ? '0 : work_q;
    rdata_d   = !io_rd ? rdata_q :
                io_addr == 2'd0 ? 32'(pattern_q) :
                io_addr == 2'd1 ? {27'b0, en_q, 2'b0, sel_q} :
                io_addr == 2'd2 ? 32'(period_q) : {15'b0, en_q, steps_q};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q <= '0;
      en_q      <= 1'b0;
      sel_q     <= 2'd0;
      period_q  <= RST_PERIOD;
      presc_q   <= '0;
      phase_q   <= 1'b0;
      work_q    <= '0;
      steps_q   <= '0;
      led_q     <= '0;
      rdata_q   <= '0;
    end else begin
      pattern_q <= pattern_d;
      en_q      <= en_d;
      sel_q     <= sel_d;
      period_q  <= period_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      work_q    <= work_d;
      steps_q   <= steps_d;
      led_q     <= led_d;
      rdata_q   <= rdata_d;
    end
  end
  assign led_data  = led_q;
  assign read_data = rdata_q;
  assign step_tick = tick;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed plus randomized checking of led_pattern_ctrl against a behavioural model
module tb_led_pattern_ctrl;
  logic        clk = 1'b0, rst = 1'b0, io_wr = 1'b0, io_rd = 1'b0;
  logic [1:0]  io_addr = 2'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic [15:0] led_data;
  logic        step_tick;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  led_pattern_ctrl dut (
    .clk(clk), .rst(rst), .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr),
    .write_data(write_data), .read_data(read_data), .led_data(led_data), .step_tick(step_tick)
  );
  // Model: work is the base pattern rotated by a net offset; blink phase is the parity of blink steps;
  // the prescaler is the number of enabled cycles since the last restart or step.
  logic [15:0] m_pattern = 16'd0, m_base = 16'd0, m_led = 16'd0;
  logic [23:0] m_period = 24'd49999;
  logic [31:0] m_rdata = 32'd0;
  logic [1:0]  m_sel = 2'd0;
  logic        m_en = 1'b0, m_tk;
  int m_rot = 0, m_blinks = 0, m_since = 0, m_steps = 0;
  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    logic [31:0] t;
    t = {v, v} << (((n % 16) + 16) % 16);
    return t[31:16];
  endfunction
  function automatic logic m_tick();
    return m_en && m_since == int'(m_period) && !(io_wr && io_addr != 2'd3);
  endfunction
  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0: return {16'd0, m_pattern};
      2'd1: return {27'd0, m_en, 2'b0, m_sel};
      2'd2: return {8'd0, m_period};
      default: return {15'd0, m_en, 16'(m_steps)};
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_pattern = 0; m_sel = 0; m_en = 0; m_period = 24'd49999; m_base = 0;
      m_rot = 0; m_blinks = 0; m_since = 0; m_steps = 0; m_led = 0; m_rdata = 0;
    end else begin
      m_tk  = m_tick();
      m_led = !m_en ? m_pattern : (m_sel == 2'd1 && m_blinks % 2 == 1) ? 16'd0 : rotl(m_base, m_rot);
      if (io_rd) m_rdata = m_read(io_addr);
      if (io_wr && io_addr != 2'd3) begin
        if (io_addr == 2'd0) m_pattern = write_data[15:0];
        if (io_addr == 2'd1) begin m_en = write_data[4]; m_sel = write_data[1:0]; end
        if (io_addr == 2'd2) m_period = write_data[23:0];
        m_base = m_pattern; m_rot = 0; m_blinks = 0; m_since = 0;
      end else if (m_tk) begin
        m_steps = (m_steps + 1) % 65536;
        m_since = 0;
        if (m_sel == 2'd1) m_blinks++;
        if (m_sel == 2'd2) m_rot = (m_rot + 1) % 16;
        if (m_sel == 2'd3) m_rot = (m_rot + 15) % 16;
      end else if (m_en) m_since++;
    end
  end
  initial forever begin
    @(negedge clk);
    chk("led", 32'(led_data), 32'(m_led));
    chk("rdata", read_data, m_rdata);
    chk("tick", 32'(step_tick), 32'(m_tick()));
  end
  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    io_addr = a; write_data = d; io_wr = 1'b1; cyc(); io_wr = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    io_addr = a; io_rd = 1'b1; cyc(); io_rd = 1'b0; v = read_data;
  endtask
  task automatic wait_tick();
    for (int i = 0; i < 1000; i++) begin
      if (step_tick) return;
      cyc();
    end
    checks++; errors++;
    $display("FAIL wait_tick: got no step_tick expected one within 1000 cycles");
  endtask
  logic [31:0] v;
  logic [15:0] a, b, led_hist[256];
  int tick_at[16], ticks, nt;
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_led", 32'(led_data), 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    rd(2'd2, v); chk("rst_period", v, 32'd49999);
    wr(2'd0, 32'h00A5); wr(2'd1, 32'h0);
    chk("static_led", 32'(led_data), 32'h00A5);
    nt = 0;
    for (int i = 0; i < 100; i++) begin if (step_tick) nt++; cyc(); end
    chk("static_ticks", 32'(nt), 32'd0);
    chk("static_hold", 32'(led_data), 32'h00A5);
    wr(2'd0, 32'h0001); wr(2'd2, 32'd3); wr(2'd1, 32'h12);
    ticks = 0;
    for (int i = 0; i < 200 && ticks < 16; i++) begin
      led_hist[i] = led_data;
      if (step_tick) begin tick_at[ticks] = i; ticks++; end
      cyc();
    end
    chk("rotl_ticks", 32'(ticks), 32'd16);
    chk("rotl_space0", 32'(tick_at[1] - tick_at[0]), 32'd4);
    chk("rotl_space14", 32'(tick_at[15] - tick_at[14]), 32'd4);
    chk("rotl_step1", 32'(led_hist[tick_at[0] + 2]), 32'h0002);
    chk("rotl_step2", 32'(led_hist[tick_at[1] + 2]), 32'h0004);
    cyc();
    chk("rotl_wrap", 32'(led_data), 32'h0001);
    rd(2'd3, v); chk("rotl_status", v, 32'h0001_0010);
    wr(2'd0, 32'h8001); wr(2'd2, 32'd1); wr(2'd1, 32'h13);
    wait_tick(); cyc(); cyc();
    chk("rotr_1", 32'(led_data), 32'hC000);
    chk("rotr_tick1", 32'(step_tick), 32'd1);
    cyc(); cyc();
    chk("rotr_2", 32'(led_data), 32'h6000);
    chk("rotr_tick2", 32'(step_tick), 32'd1);
    io_addr = 2'd0; write_data = 32'h00F0; io_wr = 1'b1;
    #1 chk("wr_wins_tick", 32'(step_tick), 32'd0);
    @(posedge clk); #1 io_wr = 1'b0;
    chk("wr_wins_next", 32'(step_tick), 32'd0);
    cyc();
    chk("wr_wins_led", 32'(led_data), 32'h00F0);
    chk("wr_wins_retick", 32'(step_tick), 32'd1);
    wr(2'd0, 32'hFFFF); wr(2'd2, 32'd0); wr(2'd1, 32'h11);
    cyc(); a = led_data; cyc(); b = led_data;
    chk("blink_on", 32'(a), 32'hFFFF);
    chk("blink_off", 32'(b), 32'h0000);
    wr(2'd1, 32'h0);
    cyc(); chk("blink_stop", 32'(led_data), 32'hFFFF);
    cyc(); chk("blink_hold", 32'(led_data), 32'hFFFF);
    wr(2'd0, 32'h0003); wr(2'd2, 32'd2); wr(2'd1, 32'h12);
    repeat (7) cyc();
    #2 rst = 1'b0;
    #1 chk("arst_led", 32'(led_data), 32'd0);
    chk("arst_rdata", read_data, 32'd0);
    chk("arst_tick", 32'(step_tick), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    rd(2'd3, v); chk("arst_status", v, 32'd0);
    rd(2'd1, v); chk("arst_mode", v, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      io_wr = $urandom_range(0, 15) == 0;
      io_rd = $urandom_range(0, 3) == 0;
      io_addr = 2'($urandom_range(0, 3));
      write_data = io_addr == 2'd2 ? {8'($urandom), 24'($urandom_range(0, 4))} : $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
      end else cyc();
    end
    io_wr = 1'b0; io_rd = 1'b0;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Memory-mapped LED sequencer on the IO bus. It drives the board's 16 LEDs from a CPU-programmed pattern.
- Supports four modes: static, blink, rotate-left and rotate-right.
- Step timing comes from a programmable prescaler, so software only writes configuration registers and no longer bit-bangs the LEDs.
- Sits between the MMIO decoder (which supplies io_wr, io_rd and io_addr) and the LED pins.

Parameters:
- LED_W, 16, width of the LED output and of the PATTERN register.
- CNT_W, 24, width of the PERIOD register and the prescaler counter.
- RST_PERIOD, 24'd49999, PERIOD value loaded at reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low.
- io_wr  input  1  single-cycle write strobe, already qualified by the address decoder.
- io_rd  input  1  single-cycle read strobe, already qualified by the address decoder.
- io_addr  input  2  register select: 0=PATTERN, 1=MODE, 2=PERIOD, 3=STATUS.
- write_data  input  32  write payload.
- read_data  output  32  registered read data.
- led_data  output  LED_W  LED drive.
- step_tick  output  1  one-cycle pulse on every sequencer step.

Behaviour:
- Reset (rst=0, asynchronous):
  - PATTERN=0, MODE=0 (EN=0, SEL=0), PERIOD=RST_PERIOD.
  - work=0, phase=0, presc=0, steps=0.
  - led_data=0, read_data=0, step_tick=0.
  - Assertion mid-sequence aborts immediately with no further steps. After release, the first posedge behaves as from cold reset.
- Registers:
  - PATTERN: bits[LED_W-1:0].
  - MODE: bit0=SEL0, bit1=SEL1, bit4=EN. Other bits are write-ignored and read as 0.
  - PERIOD: bits[CNT_W-1:0].
  - STATUS: read-only, {15'b0, EN, steps[15:0]}. Writes to STATUS are ignored.
- Write side effects:
  - A write to PATTERN, MODE or PERIOD sets presc=0, phase=0 and work=new PATTERN (or the current PATTERN for MODE/PERIOD writes).
  - Steps are not cleared by these writes; a STATUS write is ignored entirely.
- Prescaler:
  - Runs only when EN=1.
  - presc counts 0..PERIOD. When presc==PERIOD and EN=1: presc->0, step_tick=1 for that cycle.
  - One tick every PERIOD+1 cycles. PERIOD=0 gives a tick every cycle.
  - When EN=0: presc holds 0 and step_tick=0.
- Step action on tick, by SEL:
  - 0 static: no change to work.
  - 1 blink: phase toggles.
  - 2 rotate-left: work={work[LED_W-2:0], work[LED_W-1]}.
  - 3 rotate-right: work={work[0], work[LED_W-1:1]}.
  - steps increments on every tick, modulo 2^16, wrapping 0xFFFF->0.
- Simultaneous write and tick in the same cycle: the write wins.
  - The tick is suppressed: no step, no steps increment, and step_tick=0.
  - Write side effects apply as above.
- Output:
  - EN=0: led_data=PATTERN (static, regardless of SEL).
  - EN=1, SEL=1: led_data = phase ? 0 : work.
  - Otherwise: led_data=work.
  - led_data is registered, so a register write reaches led_data one cycle after the write edge.
  - Rotation of pattern 0 or all-ones is a no-op; this is legal.
- Reads:
  - read_data is updated on the posedge where io_rd=1 and holds otherwise. Data is valid in the cycle after io_rd.
  - Simultaneous io_rd and io_wr to the same address returns the old value.

Test Plan:
- Reset release, no writes -> led_data=0, read_data=0. Read of PERIOD returns 49999.
- Write PATTERN=0x00A5, MODE=0x00 -> led_data=0x00A5 one cycle later. No step_tick over 100 cycles.
- PATTERN=0x0001, PERIOD=3, MODE=0x12 (EN, rotate-left):
  - step_tick every 4 cycles.
  - led_data steps 0x0001->0x0002->0x0004. After 16 ticks led_data=0x0001 and STATUS[15:0]=16.
- PATTERN=0x8001, PERIOD=1, MODE=0x13 (rotate-right):
  - led_data 0x8001->0xC000->0x6000.
  - Write PATTERN=0x00F0 on a tick cycle -> no step that cycle; led_data=0x00F0; the next tick arrives 2 cycles later.
- Blink, PATTERN=0xFFFF, PERIOD=0:
  - led_data alternates 0xFFFF/0x0000 every cycle.
  - Write MODE=0x00 -> led_data=0xFFFF and holds.
- Rotate running with PERIOD=2, pull rst low for 1 cycle mid-period:
  - Immediately led_data=0 and STATUS=0.
  - After release, MODE reads 0.
